// File: rtl/spi_pkg.sv
// Shared constants and helpers for the word-oriented SPI slave.
package spi_pkg;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // SCLK level reached by the sample edge and by the shift edge.
  typedef struct packed {
    logic sample_lvl;
    logic shift_lvl;
  } edge_role_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic edge_role_t edge_roles(input logic cpol, input logic cpha);
    edge_role_t role;
    role.sample_lvl = ({cpol, cpha} == SPI_MODE0) || ({cpol, cpha} == SPI_MODE3);
    role.shift_lvl  = ({cpol, cpha} == SPI_MODE1) || ({cpol, cpha} == SPI_MODE2);
    return role;
  endfunction

endpackage

// File: rtl/spi_slave_word_if.sv
// User-side receive/transmit handshake of the SPI slave.
interface spi_slave_word_if #(parameter int WIDTH = 8);
  logic             rxValid;
  logic [WIDTH-1:0] rxData;
  logic             rxAbort;
  logic [WIDTH-1:0] txData;
  logic             txValid;
  logic             txReady;
  logic             txUnderrun;
  logic             busy;

  modport slave (
    output rxValid, rxData, rxAbort, txReady, txUnderrun, busy,
    input  txData, txValid
  );

  modport master (
    input  rxValid, rxData, rxAbort, txReady, txUnderrun, busy,
    output txData, txValid
  );
endinterface

// File: rtl/spi_sync_edge.sv
// N-flop synchroniser followed by a rise/fall detector with a selectable reset level.
module spi_sync_edge #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_slave_word.sv
// Oversampling SPI slave: configurable word width, mode and bit order,
// with a one-word transmit holding register.
module spi_slave_word
  import spi_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter bit              CPOL      = 1'b1,
  parameter bit              CPHA      = 1'b1,
  parameter bit              LSB_FIRST = 1'b0,
  parameter logic [WIDTH-1:0] TX_IDLE  = '1
) (
  input  logic sysClk,
  input  logic usrReset,
  input  logic SCLK,
  input  logic MOSI,
  output wire  MISO,
  input  logic SS,
  spi_slave_word_if.slave usr
);
  localparam int               CW   = clog2(WIDTH);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam edge_role_t       ROLE = edge_roles(CPOL, CPHA);

  logic sclk_q, sclk_rise, sclk_fall;
  logic ss_q, ss_rise, ss_fall;
  logic [1:0] mosi_s;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rx_sh, tx_sh, hold;
  logic             tx_ready, pf;

  spi_sync_edge #(.STAGES(2), .RST_VAL(CPOL)) u_sclk (
    .clk(sysClk), .rst(usrReset), .d(SCLK), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(2), .RST_VAL(1'b1)) u_ss (
    .clk(sysClk), .rst(usrReset), .d(SS), .q(ss_q), .rise(ss_rise), .fall(ss_fall)
  );

  // An SS falling edge wins over any SCLK edge seen in the same cycle.
  wire live      = ~ss_q & ~ss_fall;
  wire sclk_edge = sclk_rise | sclk_fall;
  wire sample_ev = live & sclk_edge & (sclk_q == ROLE.sample_lvl);
  wire shift_ev  = live & sclk_edge & (sclk_q == ROLE.shift_lvl);
  wire word_edge = shift_ev & (cnt == '0);
  wire load_ev   = CPHA ? word_edge : (word_edge | (ss_fall & ~pf));
  wire accept    = usr.txValid & tx_ready;

  wire [WIDTH-1:0] rx_next = LSB_FIRST ? {mosi_s[1], rx_sh[WIDTH-1:1]}
                                       : {rx_sh[WIDTH-2:0], mosi_s[1]};
  wire [WIDTH-1:0] tx_next = LSB_FIRST ? {1'b1, tx_sh[WIDTH-1:1]}
                                       : {tx_sh[WIDTH-2:0], 1'b1};

  always_ff @(posedge sysClk) begin
    if (usrReset) begin
      mosi_s         <= '0;
      cnt            <= '0;
      rx_sh          <= '0;
      tx_sh          <= TX_IDLE;
      hold           <= '0;
      tx_ready       <= 1'b1;
      pf             <= 1'b0;
      usr.rxData     <= '0;
      usr.rxValid    <= 1'b0;
      usr.rxAbort    <= 1'b0;
      usr.txUnderrun <= 1'b0;
    end else begin
      mosi_s         <= {mosi_s[0], MOSI};
      usr.rxValid    <= 1'b0;
      usr.rxAbort    <= 1'b0;
      usr.txUnderrun <= 1'b0;

      if (accept) begin
        hold     <= usr.txData;
        tx_ready <= 1'b0;
      end

      if (ss_fall) begin
        cnt   <= '0;
        rx_sh <= '0;
      end else if (ss_rise) begin
        if (cnt != '0) usr.rxAbort <= 1'b1;
        cnt <= '0;
      end else if (sample_ev) begin
        rx_sh <= rx_next;
        pf    <= 1'b0;
        if (cnt == LAST) begin
          cnt         <= '0;
          usr.rxData  <= rx_next;
          usr.rxValid <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      // A word accepted in this cycle lands in hold only; it never bypasses into the shifter.
      if (load_ev) begin
        if (!tx_ready) begin
          tx_sh    <= hold;
          tx_ready <= 1'b1;
        end else begin
          tx_sh          <= TX_IDLE;
          usr.txUnderrun <= 1'b1;
        end
        pf <= ~CPHA & shift_ev;
      end else if (shift_ev) begin
        tx_sh <= tx_next;
      end

      if (ss_fall) pf <= 1'b0;
    end
  end

  assign usr.txReady = tx_ready;
  assign usr.busy    = ~ss_q;
  assign MISO        = ss_q ? 1'bz : (LSB_FIRST ? tx_sh[0] : tx_sh[WIDTH-1]);
endmodule

// File: tb/tb_spi_slave_word.sv
// Four slaves, one per SPI mode, driven by a bit-banged master; a monitor
// pops expected receive words from a scoreboard queue as rxValid pulses.
module tb_spi_slave_word;
  localparam int H = 8;

  logic       sysClk = 1'b0;
  logic       usrReset = 1'b1;
  logic [3:0] ss = 4'b1111;
  logic [3:0] sclk = 4'b1100;
  logic       mosi = 1'b0;
  wire        miso0, miso1, miso2, miso3;
  pullup (miso0);
  pullup (miso1);
  pullup (miso2);
  pullup (miso3);
  wire [3:0]  miso_v = {miso3, miso2, miso1, miso0};

  int checks = 0;
  int errors = 0;
  int act_abort [4];
  int act_unr   [4];

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 sysClk = ~sysClk;

  spi_slave_word_if #(.WIDTH(16)) if0 ();
  spi_slave_word_if #(.WIDTH(8))  if1 ();
  spi_slave_word_if #(.WIDTH(8))  if2 ();
  spi_slave_word_if #(.WIDTH(8))  if3 ();

  spi_slave_word #(.WIDTH(16), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b1)) u0 (
    .sysClk(sysClk), .usrReset(usrReset), .SCLK(sclk[0]), .MOSI(mosi),
    .MISO(miso0), .SS(ss[0]), .usr(if0));
  spi_slave_word #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b1), .LSB_FIRST(1'b0)) u1 (
    .sysClk(sysClk), .usrReset(usrReset), .SCLK(sclk[1]), .MOSI(mosi),
    .MISO(miso1), .SS(ss[1]), .usr(if1));
  spi_slave_word #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b0), .LSB_FIRST(1'b0)) u2 (
    .sysClk(sysClk), .usrReset(usrReset), .SCLK(sclk[2]), .MOSI(mosi),
    .MISO(miso2), .SS(ss[2]), .usr(if2));
  spi_slave_word #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b0)) u3 (
    .sysClk(sysClk), .usrReset(usrReset), .SCLK(sclk[3]), .MOSI(mosi),
    .MISO(miso3), .SS(ss[3]), .usr(if3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check(input int idx, input logic [31:0] d);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL rx_unexpected: slave %0d got %h, expected no word", idx, d);
    end else begin
      e = sb.pop_front();
      if (e.idx != idx || e.data !== d) begin
        errors++;
        $display("FAIL rx_word: slave %0d got %h, expected slave %0d word %h", idx, d, e.idx, e.data);
      end
    end
  endtask

  always @(negedge sysClk) begin
    if (if0.rxValid) sb_check(0, 32'(if0.rxData));
    if (if1.rxValid) sb_check(1, 32'(if1.rxData));
    if (if2.rxValid) sb_check(2, 32'(if2.rxData));
    if (if3.rxValid) sb_check(3, 32'(if3.rxData));
    if (if0.rxAbort) act_abort[0]++;
    if (if1.rxAbort) act_abort[1]++;
    if (if2.rxAbort) act_abort[2]++;
    if (if3.rxAbort) act_abort[3]++;
    if (if0.txUnderrun) act_unr[0]++;
    if (if1.txUnderrun) act_unr[1]++;
    if (if2.txUnderrun) act_unr[2]++;
    if (if3.txUnderrun) act_unr[3]++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge sysClk);
  endtask

  task automatic expect_rx(input int idx, input logic [31:0] d);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic set_tx(input int idx, input logic v, input logic [31:0] d);
    case (idx)
      0: begin if0.txValid = v; if0.txData = d[15:0]; end
      1: begin if1.txValid = v; if1.txData = d[7:0]; end
      2: begin if2.txValid = v; if2.txData = d[7:0]; end
      default: begin if3.txValid = v; if3.txData = d[7:0]; end
    endcase
  endtask

  function automatic logic rdy(input int idx);
    case (idx)
      0: return if0.txReady;
      1: return if1.txReady;
      2: return if2.txReady;
      default: return if3.txReady;
    endcase
  endfunction

  task automatic push_tx(input int idx, input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    @(negedge sysClk);
    set_tx(idx, 1'b1, d);
    for (int t = 0; t < 50 && !ok; t++) begin
      ok = rdy(idx);
      @(negedge sysClk);
    end
    set_tx(idx, 1'b0, d);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tx_handshake: slave %0d txReady stayed 0, expected 1 within 50 cycles", idx);
    end
  endtask

  // Mode is the slave index; slave 0 is the 16-bit LSB-first one.
  task automatic xfer(input int idx, input logic [31:0] dout, input int nbits, output logic [31:0] din);
    logic cpol, cpha, lsb;
    int   w, b;
    cpol = (idx >= 2);
    cpha = (idx == 1 || idx == 3);
    lsb  = (idx == 0);
    w    = (idx == 0) ? 16 : 8;
    din  = '0;
    for (int i = 0; i < nbits; i++) begin
      b = lsb ? i : w - 1 - i;
      if (!cpha) begin
        mosi = dout[b];
        wait_clk(H);
        din[b] = miso_v[idx];
        sclk[idx] = ~cpol;
        wait_clk(H);
        sclk[idx] = cpol;
      end else begin
        sclk[idx] = ~cpol;
        mosi = dout[b];
        wait_clk(H);
        din[b] = miso_v[idx];
        sclk[idx] = cpol;
        wait_clk(H);
      end
    end
  endtask

  initial begin
    logic [31:0] din;
    if0.txValid = 1'b0; if0.txData = '0;
    if1.txValid = 1'b0; if1.txData = '0;
    if2.txValid = 1'b0; if2.txData = '0;
    if3.txValid = 1'b0; if3.txData = '0;
    wait_clk(3);
    usrReset = 1'b0;
    wait_clk(2);

    chk("rst_rxData", 32'(if3.rxData), 32'h0);
    chk("rst_txReady", 32'(if3.txReady), 32'h1);
    chk("rst_busy", 32'(if3.busy), 32'h0);
    chk("rst_miso_z", 32'(miso_v[3]), 32'h1);

    // Mode 3: preloaded 0x3C goes out while 0xA5 comes in
    push_tx(3, 32'h3C);
    chk("m3_txReady_full", 32'(if3.txReady), 32'h0);
    expect_rx(3, 32'hA5);
    ss[3] = 1'b0;
    wait_clk(H);
    chk("m3_busy", 32'(if3.busy), 32'h1);
    xfer(3, 32'hA5, 8, din);
    wait_clk(4);
    ss[3] = 1'b1;
    wait_clk(H);
    chk("m3_miso_word", din, 32'h3C);
    chk("m3_txReady_after", 32'(if3.txReady), 32'h1);

    // Mode 0, 16-bit LSB-first, two words back to back
    push_tx(0, 32'h0F0F);
    ss[0] = 1'b0;
    wait_clk(6);
    push_tx(0, 32'hF0F0);
    expect_rx(0, 32'h1234);
    xfer(0, 32'h1234, 16, din);
    chk("m0_miso_w0", din, 32'h0F0F);
    wait_clk(6);
    push_tx(0, 32'hAAAA);
    expect_rx(0, 32'hBEEF);
    xfer(0, 32'hBEEF, 16, din);
    chk("m0_miso_w1", din, 32'hF0F0);
    wait_clk(H);
    ss[0] = 1'b1;
    wait_clk(H);

    // Mode 1 with nothing to send
    expect_rx(1, 32'h96);
    ss[1] = 1'b0;
    wait_clk(H);
    xfer(1, 32'h96, 8, din);
    wait_clk(4);
    ss[1] = 1'b1;
    wait_clk(H);
    chk("m1_underrun_word", din, 32'hFF);

    // Frame cut after 5 bits, then a full one
    ss[3] = 1'b0;
    wait_clk(H);
    xfer(3, 32'hB7, 5, din);
    wait_clk(4);
    ss[3] = 1'b1;
    wait_clk(H);
    chk("abort_rxData_kept", 32'(if3.rxData), 32'hA5);
    chk("abort_pulse", 32'(act_abort[3]), 32'd1);
    expect_rx(3, 32'h5A);
    ss[3] = 1'b0;
    wait_clk(H);
    xfer(3, 32'h5A, 8, din);
    wait_clk(4);
    ss[3] = 1'b1;
    wait_clk(H);

    // Mode 2 prefetch retained across an SS gap
    push_tx(2, 32'h11);
    ss[2] = 1'b0;
    wait_clk(6);
    push_tx(2, 32'h22);
    expect_rx(2, 32'hC3);
    xfer(2, 32'hC3, 8, din);
    chk("pf_first_word", din, 32'h11);
    wait_clk(H);
    ss[2] = 1'b1;
    wait_clk(2 * H);
    ss[2] = 1'b0;
    wait_clk(6);
    push_tx(2, 32'h33);
    expect_rx(2, 32'h3C);
    xfer(2, 32'h3C, 8, din);
    chk("pf_retained_word", din, 32'h22);
    wait_clk(H);
    ss[2] = 1'b1;
    wait_clk(H);
    chk("pf_no_underrun", 32'(act_unr[2]), 32'd0);

    // SCLK activity with SS high is ignored
    for (int i = 0; i < 20; i++) begin
      sclk[3] = ~sclk[3];
      mosi = 1'($urandom);
      wait_clk(H / 2);
    end
    chk("ss_high_miso_z", 32'(miso_v[3]), 32'h1);
    expect_rx(3, 32'hC3);
    ss[3] = 1'b0;
    wait_clk(H);
    xfer(3, 32'hC3, 8, din);
    wait_clk(4);
    ss[3] = 1'b1;
    wait_clk(H);

    // Reset in the middle of a word
    ss[3] = 1'b0;
    wait_clk(H);
    xfer(3, 32'hFF, 4, din);
    usrReset = 1'b1;
    wait_clk(1);
    chk("rstmid_rxData", 32'(if3.rxData), 32'h0);
    chk("rstmid_rxValid", 32'(if3.rxValid), 32'h0);
    chk("rstmid_rxAbort", 32'(if3.rxAbort), 32'h0);
    chk("rstmid_txUnderrun", 32'(if3.txUnderrun), 32'h0);
    chk("rstmid_txReady", 32'(if3.txReady), 32'h1);
    chk("rstmid_busy", 32'(if3.busy), 32'h0);
    chk("rstmid_miso_z", 32'(miso_v[3]), 32'h1);
    usrReset = 1'b0;
    wait_clk(H);
    ss[3] = 1'b1;
    wait_clk(2 * H);

    chk("abort_cnt_0", 32'(act_abort[0]), 32'd0);
    chk("abort_cnt_1", 32'(act_abort[1]), 32'd0);
    chk("abort_cnt_2", 32'(act_abort[2]), 32'd0);
    chk("abort_cnt_3", 32'(act_abort[3]), 32'd1);
    chk("unr_cnt_0", 32'(act_unr[0]), 32'd0);
    chk("unr_cnt_1", 32'(act_unr[1]), 32'd1);
    chk("unr_cnt_2", 32'(act_unr[2]), 32'd0);
    chk("unr_cnt_3", 32'(act_unr[3]), 32'd4);
    chk("rx_words_left", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end
endmodule
